// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle processor core with writable instruction memory,
// register file, program counter and a FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-low reset
//   start        run request, honoured only in IDLE or HALTED
//   prog_we      instruction memory write enable (IDLE/HALTED only)
//   prog_addr    instruction memory write address
//   prog_data    instruction memory write data
//   inst_out     current instruction register
//   mem_data_out last value written back to the register file
//   pc_out       program counter
//   busy         high in FETCH, DECODE, EXECUTE and WRITEBACK
//   halted       high in HALTED
//   wb_valid     one-cycle pulse per register file write
//
// Instruction format, MSB first: [op(3) | dest | src1 | src2].
module multicycle_cpu #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 2,
    parameter int PC_W       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      prog_we,
    input  logic [PC_W-1:0]           prog_addr,
    input  logic [3+3*REG_ADDR_W-1:0] prog_data,
    output logic [3+3*REG_ADDR_W-1:0] inst_out,
    output logic [DATA_W-1:0]         mem_data_out,
    output logic [PC_W-1:0]           pc_out,
    output logic                      busy,
    output logic                      halted,
    output logic                      wb_valid
);

    localparam int INST_W = 3 + 3*REG_ADDR_W;
    localparam int NREGS  = 2**REG_ADDR_W;
    localparam int NWORDS = 2**PC_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_LDI  = 3'd5,
        OP_JMP  = 3'd6,
        OP_HALT = 3'd7
    } op_t;

    state_t                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [INST_W-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [DATA_W-1:0]     res_q, res_d;
    logic [DATA_W-1:0]     mdo_q, mdo_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]     rf_q [NREGS];
    logic [DATA_W-1:0]     rf_d [NREGS];
    logic [INST_W-1:0]     imem_q [NWORDS];
    logic                  imem_we;

    op_t                   op;
    logic [REG_ADDR_W-1:0] dest, src1, src2;
    logic                  idle_or_halted;

    assign op   = op_t'(ir_q[INST_W-1 -: 3]);
    assign dest = ir_q[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign src1 = ir_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign src2 = ir_q[REG_ADDR_W-1:0];

    assign idle_or_halted = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign imem_we        = prog_we && idle_or_halted;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        mdo_d      = mdo_q;
        wb_valid_d = 1'b0;
        rf_d       = rf_q;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = imem_q[pc_q];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = rf_q[src1];
                b_d     = rf_q[src2];
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
                unique case (op)
                    OP_ADD:  res_d = a_q + b_q;
                    OP_SUB:  res_d = a_q - b_q;
                    OP_AND:  res_d = a_q & b_q;
                    OP_OR:   res_d = a_q | b_q;
                    OP_XOR:  res_d = a_q ^ b_q;
                    OP_LDI:  res_d = DATA_W'({src1, src2});
                    OP_JMP: begin
                        pc_d    = PC_W'({dest, src1, src2});
                        state_d = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALTED;
                endcase
            end
            S_WRITEBACK: begin
                rf_d[dest] = res_q;
                mdo_d      = res_q;
                wb_valid_d = 1'b1;
                pc_d       = pc_q + 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            mdo_q      <= '0;
            wb_valid_q <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            mdo_q      <= mdo_d;
            wb_valid_q <= wb_valid_d;
            rf_q       <= rf_d;
        end
    end

    // Program memory survives reset so a loaded program can be rerun.
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[prog_addr] <= prog_data;
    end

    assign inst_out     = ir_q;
    assign mem_data_out = mdo_q;
    assign pc_out       = pc_q;
    assign wb_valid     = wb_valid_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                          (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
    assign halted       = (state_q == S_HALTED);

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs for multicycle_cpu. Expected writeback
// values are queued as each program is issued; a monitor pops one per
// wb_valid pulse and compares it with mem_data_out.
module tb_multicycle_cpu;

    logic       clk;
    logic       reset;
    logic       start;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [8:0] prog_data;
    logic [8:0] inst_out;
    logic [7:0] mem_data_out;
    logic [3:0] pc_out;
    logic       busy;
    logic       halted;
    logic       wb_valid;

    int vectors;
    int miscompares;
    logic [7:0] exp_q [$];

    multicycle_cpu #(.DATA_W(8), .REG_ADDR_W(2), .PC_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .inst_out     (inst_out),
        .mem_data_out (mem_data_out),
        .pc_out       (pc_out),
        .busy         (busy),
        .halted       (halted),
        .wb_valid     (wb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && wb_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wb_unexpected: mem_data_out=%02h, no writeback expected", mem_data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (mem_data_out !== e) begin
                    miscompares++;
                    $display("FAIL wb_data: got %02h expected %02h", mem_data_out, e);
                end
            end
        end
    end

    function automatic logic [8:0] enc(input int op, input int d, input int s1, input int s2);
        logic [2:0] o;
        logic [1:0] dd, a, b;
        o = 3'(op); dd = 2'(d); a = 2'(s1); b = 2'(s2);
        return {o, dd, a, b};
    endfunction

    function automatic logic [8:0] ldi(input int d, input int imm);
        logic [3:0] v;
        v = 4'(imm);
        return enc(5, d, int'(v[3:2]), int'(v[1:0]));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_inst"}, 32'(inst_out), 0);
        check({name, "_mdo"},  32'(mem_data_out), 0);
        check({name, "_pc"},   32'(pc_out), 0);
        check({name, "_flags"}, {29'd0, busy, halted, wb_valid}, 0);
    endtask

    task automatic prog_write(input int addr, input logic [8:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'(addr); prog_data = data;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halted(input string name, output int cycles);
        cycles = 0;
        while (halted !== 1'b1 && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({name, "_halted"}, 32'(halted), 1);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_drained(input string name, output int max_pc);
        int n;
        n = 0;
        max_pc = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            if (int'(pc_out) > max_pc) max_pc = int'(pc_out);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int cyc, mx;
        vectors = 0; miscompares = 0;
        reset = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        #1;
        check_all_zero("reset_init");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Program 1: LDI r1,3; LDI r2,5; ADD r3,r1,r2; HALT
        prog_write(0, ldi(1, 3));
        prog_write(1, ldi(2, 5));
        prog_write(2, enc(0, 3, 1, 2));
        prog_write(3, enc(7, 0, 0, 0));
        exp_q.push_back(8'h03); exp_q.push_back(8'h05); exp_q.push_back(8'h08);
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        wait_halted("p1", cyc);
        check("p1_pc", 32'(pc_out), 3);
        check("p1_mdo_hold", 32'(mem_data_out), 8'h08);
        check("p1_ir_halt", 32'(inst_out), 32'(enc(7, 0, 0, 0)));

        // Program 2: SUB r0,r1,r2 relies on retained r1=3, r2=5
        prog_write(0, enc(1, 0, 1, 2));
        prog_write(1, enc(7, 0, 0, 0));
        exp_q.push_back(8'hFE);
        pulse_start();
        wait_halted("p2", cyc);
        check("p2_pc", 32'(pc_out), 1);

        // Program 3: doubling loop via JMP 1
        prog_write(0, ldi(1, 1));
        prog_write(1, enc(0, 1, 1, 1));
        prog_write(2, enc(6, 0, 0, 1));
        exp_q.push_back(8'h01);
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'((1 << i) & 8'hFF));
        pulse_start();
        wait_drained("p3", mx);
        check("p3_pc_max", 32'(mx <= 2), 1);
        reset = 1'b0;
        #1;
        check_all_zero("reset_p3");
        @(posedge clk); #1 reset = 1'b1;

        // Program 4: 16 LDIs, no HALT, pc wraps 15 -> 0
        for (int i = 0; i < 16; i++) begin
            prog_write(i, ldi(i % 4, i));
            exp_q.push_back(8'(i));
        end
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        pulse_start();
        wait_drained("p4", mx);
        check("p4_pc_after_wrap", 32'(pc_out), 2);
        check("p4_pc_max", 32'(mx), 15);
        reset = 1'b0;
        #1;
        check_all_zero("reset_p4");
        @(posedge clk); #1 reset = 1'b1;

        // Program 5: reset while ADD is in EXECUTE, then rerun
        prog_write(0, ldi(1, 3));
        prog_write(1, ldi(2, 5));
        prog_write(2, enc(0, 3, 1, 2));
        prog_write(3, enc(7, 0, 0, 0));
        exp_q.push_back(8'h03); exp_q.push_back(8'h05);
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        check("p5_mdo_before_reset", 32'(mem_data_out), 8'h05);
        check("p5_ir_add", 32'(inst_out), 32'(enc(0, 3, 1, 2)));
        reset = 1'b0;
        #1;
        check_all_zero("reset_exec");
        repeat (4) @(posedge clk);
        #1;
        check("p5_no_wb_in_reset", 32'(wb_valid), 0);
        reset = 1'b1;
        exp_q.push_back(8'h03); exp_q.push_back(8'h05); exp_q.push_back(8'h08);
        pulse_start();
        wait_halted("p5", cyc);
        check("p5_pc", 32'(pc_out), 3);

        // Program 6: prog_we while busy is ignored; write with start in HALTED applies
        prog_write(0, ldi(1, 7));
        prog_write(1, enc(7, 0, 0, 0));
        exp_q.push_back(8'h07);
        pulse_start();
        check("p6_busy", 32'(busy), 1);
        prog_write(1, ldi(2, 9));
        wait_halted("p6", cyc);
        check("p6_halt_latency", 32'(cyc), 6);
        check("p6_pc", 32'(pc_out), 1);
        exp_q.push_back(8'h09);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = ldi(1, 9); start = 1'b1;
        @(posedge clk);
        #1 prog_we = 1'b0; start = 1'b0;
        wait_halted("p6b", cyc);
        check("p6b_pc", 32'(pc_out), 1);
        check("p6b_mdo", 32'(mem_data_out), 8'h09);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
